fpu_issue: RTL and testbench

FPU_ISSUE -- requirements
Module: fpu_issue

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fpu_issue.sv | 126 ++++++++++++
 tb/tb_fpu_issue.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue block: opcodes, field widths and FSM states.
package fpu_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;

  localparam logic [OP_W-1:0] OP_FADD   = 5'd0;
  localparam logic [OP_W-1:0] OP_FSUB   = 5'd1;
  localparam logic [OP_W-1:0] OP_FMUL   = 5'd2;
  localparam logic [OP_W-1:0] OP_FDIV   = 5'd3;
  localparam logic [OP_W-1:0] OP_FSQRT  = 5'd4;
  localparam logic [OP_W-1:0] OP_FHALF  = 5'd5;
  localparam logic [OP_W-1:0] OP_FMIN   = 5'd6;
  localparam logic [OP_W-1:0] OP_FMAX   = 5'd7;
  localparam logic [OP_W-1:0] OP_FABS   = 5'd8;
  localparam logic [OP_W-1:0] OP_FNEG   = 5'd9;
  localparam logic [OP_W-1:0] OP_FEQ    = 5'd10;
  localparam logic [OP_W-1:0] OP_FLT    = 5'd11;
  localparam logic [OP_W-1:0] OP_FLE    = 5'd12;
  localparam logic [OP_W-1:0] OP_FCVTWS = 5'd13;
  localparam logic [OP_W-1:0] OP_FCVTSW = 5'd14;
  localparam logic [OP_W-1:0] OP_FFLOOR = 5'd15;
  localparam logic [OP_W-1:0] OP_FCEIL  = 5'd16;
  localparam logic [OP_W-1:0] OP_FROUND = 5'd17;
  localparam logic [OP_W-1:0] OP_FTRUNC = 5'd18;
  localparam logic [OP_W-1:0] OP_FRECIP = 5'd19;
  localparam logic [OP_W-1:0] OP_FSQR   = 5'd20;
  localparam logic [OP_W-1:0] OP_MAX    = 5'd20;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/fpu_issue.sv
// Issues one operation at a time to an external FPU, waits for completion or
// timeout, and returns a tagged response.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [OP_W-1:0]   fpu_ctl,
  output logic [DATA_W-1:0] fpu_x1,
  output logic [DATA_W-1:0] fpu_x2,
  output logic              fpu_en,
  input  logic              fpu_ready,
  input  logic [DATA_W-1:0] fpu_y,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          tag_d = req_tag;
          if (op_legal(req_op)) begin
            op_d    = req_op;
            a_d     = req_a;
            b_d     = req_b;
            state_d = StIssue;
          end else begin
            // Illegal opcode answers immediately without touching the FPU.
            data_d  = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Completion takes priority over a timeout reached in the same cycle.
        if (fpu_ready) begin
          data_d  = fpu_y;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign fpu_en     = (state_q == StIssue);
  assign resp_valid = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign fpu_ctl    = op_q;
  assign fpu_x1     = a_q;
  assign fpu_x2     = b_q;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed and randomized bench for fpu_issue with a latency-programmable FPU stub.
module tb_fpu_issue;

  localparam int TO = 15;

  logic        clk, rstn;
  logic        req_valid, req_ready;
  logic [4:0]  req_op, req_tag;
  logic [31:0] req_a, req_b;
  logic [4:0]  fpu_ctl;
  logic [31:0] fpu_x1, fpu_x2, fpu_y;
  logic        fpu_en, fpu_ready;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;

  int checks = 0;
  int errors = 0;

  // FPU stub state: latency of the next launch (-1 = never completes)
  int          fpu_lat;
  bit          fpu_pend;
  int          fpu_cnt;
  logic [31:0] fpu_res;
  logic [31:0] last_data;

  fpu_issue #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_ctl(fpu_ctl), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_en(fpu_en),
    .fpu_ready(fpu_ready), .fpu_y(fpu_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fpu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    if (op == 5'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == 5'd5) return a - 32'h0080_0000;
    return a ^ {b[15:0], b[31:16]} ^ {27'd0, op};
  endfunction

  // Cycle on which resp_valid first shows, counting the accept cycle as 0.
  function automatic int exp_resp_cycle(input logic [4:0] op, input int lat);
    if (op > 5'd20) return 1;
    if (lat >= 0 && lat <= TO - 1) return 3 + lat;
    return TO + 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fpu_ready = 1'b0;
    if (fpu_pend) begin
      if (fpu_cnt == 0) begin
        fpu_ready = 1'b1;
        fpu_y     = fpu_res;
        fpu_pend  = 1'b0;
      end else begin
        fpu_cnt--;
      end
    end
    if (fpu_en && fpu_lat >= 0) begin
      fpu_pend = 1'b1;
      fpu_cnt  = fpu_lat;
      fpu_res  = fpu_model(fpu_ctl, fpu_x1, fpu_x2);
    end
  endtask

  task automatic run_txn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int lat, input int hold);
    int c, en_n, en_c, rc, exp_rc;
    bit legal, exp_err;
    logic [31:0] exp_data;
    legal    = (op <= 5'd20);
    exp_rc   = exp_resp_cycle(op, lat);
    exp_err  = !legal || exp_rc == TO + 2 && !(lat >= 0 && lat <= TO - 1);
    exp_data = exp_err ? 32'h0 : fpu_model(op, a, b);
    en_n = 0; en_c = -1; rc = -1;
    fpu_lat = lat;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    tick();
    req_valid = 1'b0;
    req_op = $urandom(); req_a = $urandom(); req_b = $urandom(); req_tag = $urandom();
    c = 1;
    while (rc < 0 && c <= 40) begin
      if (fpu_en) begin en_n++; en_c = c; end
      if (resp_valid) rc = c;
      else begin
        if (legal) begin
          chk("fpu_ctl_stable", {27'd0, fpu_ctl}, {27'd0, op});
          chk("fpu_x1_stable", fpu_x1, a);
          chk("fpu_x2_stable", fpu_x2, b);
        end
        tick();
        c++;
      end
    end
    chk("resp_cycle", rc, exp_rc);
    chk("fpu_en_count", en_n, legal ? 1 : 0);
    if (legal) chk("fpu_en_cycle", en_c, 1);
    if (rc < 0) return;
    chk("resp_data", resp_data, exp_data);
    chk("resp_tag", {27'd0, resp_tag}, {27'd0, tag});
    chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    last_data = resp_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_data", resp_data, exp_data);
      chk("hold_tag_err", {26'd0, resp_tag, resp_err}, {26'd0, tag, exp_err});
      chk("hold_ready_busy", {30'd0, req_ready, busy}, 32'd1);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("post_hs_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_hs_ready_busy", {30'd0, req_ready, busy}, 32'd2);
    fpu_pend = 1'b0;
  endtask

  initial begin
    int bad;
    logic [4:0] op;
    int lat;
    rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    fpu_ready = 1'b0; fpu_y = '0; resp_ready = 1'b0;
    fpu_lat = 0; fpu_pend = 1'b0; fpu_cnt = 0; fpu_res = '0; last_data = '0;
    #2;
    chk("rst_busy_en_valid", {29'd0, busy, fpu_en, resp_valid}, 32'd0);
    chk("rst_fpu_ctl", {27'd0, fpu_ctl}, 32'd0);
    chk("rst_fpu_x", fpu_x1 | fpu_x2, 32'd0);
    chk("rst_resp", {resp_data[26:0], resp_tag} | {31'd0, resp_err}, 32'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // fadd 1.0 + 2.0 with a 4-stage FPU
    run_txn(5'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3, 4, 0);
    chk("fadd_value", last_data, 32'h4040_0000);
    // fhalf 2.0 with a zero-stage FPU
    run_txn(5'd5, 32'h4000_0000, 32'h0, 5'd9, 0, 0);
    chk("fhalf_value", last_data, 32'h3F80_0000);
    // Illegal opcodes, including the first one past the legal range
    run_txn(5'd25, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 2, 0);
    run_txn(5'd21, 32'h1, 32'h2, 5'd30, 2, 1);
    // Highest legal opcode
    run_txn(5'd20, 32'hCAFE_F00D, 32'h0BAD_BEEF, 5'd1, 1, 0);
    // Never-ready FPU, then ready exactly on the last WAIT cycle, then one too late
    run_txn(5'd2, 32'hAAAA_5555, 32'h5555_AAAA, 5'd4, -1, 0);
    run_txn(5'd3, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd5, TO - 1, 0);
    run_txn(5'd4, 32'h1111_2222, 32'h3333_4444, 5'd6, TO, 0);
    // Back-pressured response
    run_txn(5'd7, 32'h7777_0000, 32'h0000_7777, 5'd31, 2, 5);

    // Reset in WAIT abandons the operation; the late fpu_ready must be ignored
    fpu_lat = 10;
    req_valid = 1'b1; req_op = 5'd1; req_a = 32'h5; req_b = 32'h6; req_tag = 5'd12;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_rst_busy_ready", {30'd0, req_ready, busy}, 32'd2);
    chk("async_rst_ctl_x", {27'd0, fpu_ctl} | fpu_x1 | fpu_x2, 32'd0);
    #2;
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid || busy || fpu_en) bad++;
    end
    chk("rst_abandon_no_resp", bad, 0);
    fpu_pend = 1'b0;

    for (int i = 0; i < 24; i++) begin
      op  = 5'($urandom_range(0, 23));
      lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 2));
      run_txn(op, $urandom(), $urandom(), 5'($urandom()), lat, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
